rotor_key_finder: RTL and testbench

ROTOR_KEY_FINDER -- requirements
Module: rotor_key_finder

---
 rtl/rotor_key_finder_pkg.sv | 28 ++
 rtl/single_rotor_cipher.sv | 15 +
 rtl/rotor_key_finder.sv | 114 +++++++++++
 tb/tb_rotor_key_finder.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/rotor_key_finder_pkg.sv
// rotor_key_finder_pkg: rotor/reflector tables, state encoding and mod-26 helpers.
package rotor_key_finder_pkg;
  localparam int NUM_LETTERS = 26;
  localparam int LW = 5;
  localparam int CODE_W = 8;
  typedef logic [LW-1:0] letter_t;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEARCH = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  // W = EKMFLGDQVZNTOWYHXUSPAIBRCJ, R = YRUHQSLDPXNGOKMIEBFZCWVJAT
  localparam letter_t W_TAB [NUM_LETTERS] = '{
    5'd4, 5'd10, 5'd12, 5'd5, 5'd11, 5'd6, 5'd3, 5'd16, 5'd21, 5'd25, 5'd13, 5'd19, 5'd14,
    5'd22, 5'd24, 5'd7, 5'd23, 5'd20, 5'd18, 5'd15, 5'd0, 5'd8, 5'd1, 5'd17, 5'd2, 5'd9};
  localparam letter_t WINV_TAB [NUM_LETTERS] = '{
    5'd20, 5'd22, 5'd24, 5'd6, 5'd0, 5'd3, 5'd5, 5'd15, 5'd21, 5'd25, 5'd1, 5'd4, 5'd2,
    5'd10, 5'd12, 5'd19, 5'd7, 5'd23, 5'd18, 5'd11, 5'd17, 5'd8, 5'd13, 5'd16, 5'd14, 5'd9};
  localparam letter_t R_TAB [NUM_LETTERS] = '{
    5'd24, 5'd17, 5'd20, 5'd7, 5'd16, 5'd18, 5'd11, 5'd3, 5'd15, 5'd23, 5'd13, 5'd6, 5'd14,
    5'd10, 5'd12, 5'd8, 5'd4, 5'd1, 5'd5, 5'd25, 5'd2, 5'd22, 5'd21, 5'd9, 5'd0, 5'd19};
  function automatic letter_t add26(input letter_t a, input letter_t b);
    logic [LW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s >= (LW+1)'(NUM_LETTERS) ? letter_t'(s - (LW+1)'(NUM_LETTERS)) : letter_t'(s);
  endfunction
  function automatic letter_t sub26(input letter_t a, input letter_t b);
    return a >= b ? a - b : a + LW'(NUM_LETTERS) - b;
  endfunction
endpackage

// File: rtl/single_rotor_cipher.sv
// single_rotor_cipher: one pass through rotor, reflector and back at a given rotor position.
module single_rotor_cipher
  import rotor_key_finder_pkg::*;
(
  input  letter_t letter,
  input  letter_t rotor,
  output letter_t cipher
);
  letter_t fwd, refl;
  always_comb begin
    fwd = sub26(W_TAB[add26(letter, rotor)], rotor);
    refl = add26(R_TAB[fwd], rotor);
    cipher = sub26(WINV_TAB[refl], rotor);
  end
endmodule

// File: rtl/rotor_key_finder.sv
// rotor_key_finder: stores crib pairs and searches rotor start positions for the lowest match.
module rotor_key_finder
  import rotor_key_finder_pkg::*;
#(
  parameter int CRIB_MAX = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [CODE_W-1:0] plain_in,
  input  logic [CODE_W-1:0] cipher_in,
  input  logic              clear,
  input  logic              go,
  output logic              busy,
  output logic              done,
  output logic              found,
  output logic [4:0]        key_pos,
  output logic [3:0]        crib_len,
  output logic              err
);
  localparam int AW = CRIB_MAX > 1 ? $clog2(CRIB_MAX) : 1;
  localparam logic [3:0] CMAX = 4'(CRIB_MAX);
  logic [15:0] crib_q [CRIB_MAX];
  logic [1:0] state_q, state_d;
  logic [3:0] len_q, len_d, idx_q, idx_d;
  letter_t cand_q, cand_d, key_q, key_d, rot, enc;
  logic found_q, found_d, err_q, err_d;
  logic wr_ok, legal, match, last;
  logic [15:0] pair;
  assign pair = crib_q[idx_q[AW-1:0]];
  // pair k is enciphered after the rotor has stepped k+1 times from the candidate
  assign rot = add26(add26(cand_q, letter_t'(idx_q)), letter_t'(1));
  single_rotor_cipher u_cipher (
    .letter(letter_t'(pair[15:8])),
    .rotor (rot),
    .cipher(enc)
  );
  assign match = CODE_W'(enc) == pair[7:0];
  assign last = idx_q == len_q - 4'd1;
  assign legal = plain_in < CODE_W'(NUM_LETTERS) && cipher_in < CODE_W'(NUM_LETTERS);
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    idx_d = idx_q;
    cand_d = cand_q;
    key_d = key_q;
    found_d = found_q;
    err_d = err_q;
    wr_ok = 1'b0;
    if (state_q == S_IDLE) begin
      if (clear) begin
        len_d = '0;
        found_d = 1'b0;
        key_d = '0;
        err_d = 1'b0;
      end else if (go) begin
        if (len_q == '0) err_d = 1'b1;
        else begin
          found_d = 1'b0;
          key_d = '0;
          cand_d = '0;
          idx_d = '0;
          state_d = S_SEARCH;
        end
      end else if (wr_en) begin
        wr_ok = legal && len_q < CMAX;
        len_d = wr_ok ? len_q + 4'd1 : len_q;
        err_d = err_q | ~wr_ok;
      end
    end else if (state_q == S_SEARCH) begin
      if (match && last) begin
        found_d = 1'b1;
        key_d = cand_q;
        state_d = S_DONE;
      end else if (match) idx_d = idx_q + 4'd1;
      else if (cand_q == letter_t'(NUM_LETTERS - 1)) begin
        found_d = 1'b0;
        key_d = '0;
        state_d = S_DONE;
      end else begin
        cand_d = cand_q + letter_t'(1);
        idx_d = '0;
      end
    end else state_d = S_IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q <= '0;
      idx_q <= '0;
      cand_q <= '0;
      key_q <= '0;
      found_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      idx_q <= idx_d;
      cand_q <= cand_d;
      key_q <= key_d;
      found_q <= found_d;
      err_q <= err_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) crib_q[len_q[AW-1:0]] <= {plain_in, cipher_in};
  end
  assign busy = state_q == S_SEARCH;
  assign done = state_q == S_DONE;
  assign found = found_q;
  assign key_pos = key_q;
  assign crib_len = len_q;
  assign err = err_q;
endmodule

// File: tb/tb_rotor_key_finder.sv
// tb_rotor_key_finder: table-driven buffer checks plus model-checked key searches.
module tb_rotor_key_finder;
  logic clk = 1'b0, reset = 1'b1, wr_en = 1'b0, clear = 1'b0, go = 1'b0;
  logic [7:0] plain_in = '0, cipher_in = '0;
  logic busy, done, found, err;
  logic [4:0] key_pos;
  logic [3:0] crib_len;
  int npass = 0, ntot = 0;
  int ncrib;
  int pl [8];
  int ci [8];
  string ws = "EKMFLGDQVZNTOWYHXUSPAIBRCJ";
  string rs = "YRUHQSLDPXNGOKMIEBFZCWVJAT";
  typedef struct {
    bit wr, clr, go;
    int p, c;
    int len, err, busy;
  } vec_t;
  vec_t tab [17];

  rotor_key_finder #(.CRIB_MAX(8)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .plain_in(plain_in), .cipher_in(cipher_in),
    .clear(clear), .go(go), .busy(busy), .done(done), .found(found), .key_pos(key_pos),
    .crib_len(crib_len), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int m26(input int x);
    return ((x % 26) + 26) % 26;
  endfunction

  function automatic int enc(input int p, input int r);
    int x, y;
    x = int'(ws[m26(p + r)]) - 65;
    x = int'(rs[m26(x - r)]) - 65;
    y = m26(x + r);
    for (int i = 0; i < 26; i++) if (int'(ws[i]) - 65 == y) return m26(i - r);
    return -1;
  endfunction

  function automatic void model(output bit f, output int k);
    bit ok;
    f = 0;
    k = 0;
    for (int s = 0; s < 26; s++) begin
      ok = 1;
      for (int j = 0; j < ncrib; j++) if (enc(pl[j], m26(s + j + 1)) != ci[j]) ok = 0;
      if (ok) begin
        f = 1;
        k = s;
        return;
      end
    end
  endfunction

  task automatic check(input string nm, input int act, input int exp_v);
    ntot++;
    if (act == exp_v) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
  endtask

  task automatic apply(input bit w, input bit c, input bit g, input int p, input int cc);
    @(negedge clk);
    wr_en = w;
    clear = c;
    go = g;
    plain_in = 8'(p);
    cipher_in = 8'(cc);
    @(posedge clk);
    #1;
  endtask

  task automatic start_search();
    apply(0, 1, 0, 0, 0);
    for (int j = 0; j < ncrib; j++) apply(1, 0, 0, pl[j], ci[j]);
    apply(0, 0, 1, 0, 0);
  endtask

  task automatic run_search(input string nm, output int lat);
    bit ef, bad;
    int ek, cyc;
    model(ef, ek);
    bad = 0;
    cyc = 0;
    while (!done && cyc < 26 * ncrib + 5) begin
      if (!busy) bad = 1;
      @(negedge clk);
      go = 0;
      wr_en = 0;
      clear = 0;
      @(posedge clk);
      #1;
      cyc++;
    end
    lat = cyc + 1;
    check({nm, "_done"}, int'(done), 1);
    check({nm, "_busy_held"}, int'(bad), 0);
    check({nm, "_found"}, int'(found), int'(ef));
    check({nm, "_key"}, int'(key_pos), ek);
    check({nm, "_lat_ok"}, int'(lat <= 26 * ncrib + 1), 1);
    @(posedge clk);
    #1;
    check({nm, "_pulse_end"}, int'(done), 0);
    check({nm, "_idle"}, int'(busy), 0);
    check({nm, "_hold_key"}, int'(key_pos), ek);
  endtask

  initial begin
    int lat;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_found", int'(found), 0);
    check("rst_key", int'(key_pos), 0);
    check("rst_len", int'(crib_len), 0);
    check("rst_err", int'(err), 0);
    @(negedge clk);
    reset = 0;

    tab[0] = '{0, 0, 1, 0, 0, 0, 1, 0};
    tab[1] = '{0, 1, 0, 0, 0, 0, 0, 0};
    for (int k = 0; k < 8; k++) tab[2 + k] = '{1, 0, 0, k, (k * 7 + 3) % 26, k + 1, 0, 0};
    tab[10] = '{1, 0, 0, 1, 2, 8, 1, 0};
    tab[11] = '{1, 0, 0, 26, 2, 8, 1, 0};
    tab[12] = '{0, 1, 0, 0, 0, 0, 0, 0};
    tab[13] = '{1, 0, 0, 5, 30, 0, 1, 0};
    tab[14] = '{1, 1, 0, 3, 4, 0, 0, 0};
    tab[15] = '{1, 0, 0, 0, 0, 1, 0, 0};
    tab[16] = '{1, 0, 1, 7, 7, 1, 0, 1};
    for (int i = 0; i < 17; i++) begin
      apply(tab[i].wr, tab[i].clr, tab[i].go, tab[i].p, tab[i].c);
      check($sformatf("tab%0d_len", i), int'(crib_len), tab[i].len);
      check($sformatf("tab%0d_err", i), int'(err), tab[i].err);
      check($sformatf("tab%0d_busy", i), int'(busy), tab[i].busy);
      check($sformatf("tab%0d_done", i), int'(done), 0);
    end
    ncrib = 1;
    pl[0] = 0;
    ci[0] = 0;
    run_search("wrgo", lat);

    ncrib = 3;
    pl[0] = 0; ci[0] = 13;
    pl[1] = 0; ci[1] = 13;
    pl[2] = 0; ci[2] = 20;
    start_search();
    run_search("aaa", lat);

    ncrib = 8;
    for (int j = 0; j < 8; j++) begin
      pl[j] = j;
      ci[j] = enc(j, m26(17 + j + 1));
    end
    start_search();
    run_search("start17", lat);

    ncrib = 1;
    pl[0] = 0;
    ci[0] = 0;
    start_search();
    run_search("self", lat);
    check("self_lat", lat, 27);

    for (int t = 0; t < 6; t++) begin
      int s;
      ncrib = int'($urandom_range(1, 8));
      s = int'($urandom_range(0, 25));
      for (int j = 0; j < ncrib; j++) begin
        pl[j] = int'($urandom_range(0, 25));
        ci[j] = (t % 2 == 0) ? enc(pl[j], m26(s + j + 1)) : int'($urandom_range(0, 25));
      end
      start_search();
      run_search($sformatf("rand%0d", t), lat);
    end

    ncrib = 1;
    pl[0] = 0;
    ci[0] = 0;
    start_search();
    @(negedge clk);
    go = 0;
    repeat (4) @(posedge clk);
    #3;
    check("mid_busy_before", int'(busy), 1);
    reset = 1;
    #1;
    check("mid_busy", int'(busy), 0);
    check("mid_done", int'(done), 0);
    check("mid_found", int'(found), 0);
    check("mid_key", int'(key_pos), 0);
    check("mid_len", int'(crib_len), 0);
    check("mid_err", int'(err), 0);
    @(negedge clk);
    reset = 0;
    ncrib = 3;
    pl[0] = 0; ci[0] = 13;
    pl[1] = 0; ci[1] = 13;
    pl[2] = 0; ci[2] = 20;
    start_search();
    run_search("post_rst", lat);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
